// File: rtl/soma_serial_nbits.sv
// Multi-cycle WIDTH-bit adder: DIGIT bits per clock with a registered carry between digits.
// Optional SOMA_SUB_EN adds a captured `sub` select (a - b) and a signed-overflow output `ovf`.
module soma_serial_nbits #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SOMA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SOMA_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
      $error("soma_serial_nbits: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  // Handshake: start is accepted on a clk edge only while the FSM is in IDLE or DONE;
  // busy is high exactly in RUN, done is a one-cycle pulse exactly in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]       a_sh, b_sh;
  logic                   c_reg;
  logic [CW-1:0]          cnt;
  logic [DIGIT:0]         dsum;
  logic                   last;
  logic                   accept;
  logic [WIDTH-1:0]       keep;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       sum_nx;

`ifdef SOMA_SUB_EN
  logic a_msb, b_msb;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(NDIG - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_reg};

  // The previous result stays visible until the first RUN edge, which starts from zero.
  always_comb begin
    keep   = (cnt == '0) ? '0 : sum;
    cat    = {dsum[DIGIT-1:0], keep};
    sum_nx = cat[WIDTH+DIGIT-1:DIGIT];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SOMA_SUB_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh <= a;
        cnt  <= '0;
`ifdef SOMA_SUB_EN
        // Subtraction is a + ~b + 1; the injected 1 replaces cin.
        b_sh  <= sub ? ~b : b;
        c_reg <= sub ? 1'b1 : cin;
        a_msb <= a[WIDTH-1];
        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
`else
        b_sh  <= b;
        c_reg <= cin;
`endif
      end else if (state == RUN) begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        c_reg <= dsum[DIGIT];
        cnt   <= cnt + 1'b1;
        sum   <= sum_nx;
        carry <= last ? dsum[DIGIT] : 1'b0;
`ifdef SOMA_SUB_EN
        // Signed overflow: both operands share a sign that the result's MSB does not.
        ovf <= last ? ((a_msb == b_msb) && (dsum[DIGIT-1] != a_msb)) : 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_soma_serial_nbits.sv
// Bench for soma_serial_nbits: WIDTH=8 with DIGIT=1 and DIGIT=4 instances, 10 ns clock.
// Expected results come from integer arithmetic on the operands held in a queue.
`timescale 1ns/1ps
module tb_soma_serial_nbits;

  logic       clk, rst;
  logic       start, cin, busy, done, carry;
  logic [7:0] a, b, sum;
  logic       start4, cin4, busy4, done4, carry4;
  logic [7:0] a4, b4, sum4;
`ifdef SOMA_SUB_EN
  logic sub, ovf, ovf4;
`endif

  int checks = 0;
  int passed = 0;
  logic [8:0] exp_q[$];

  soma_serial_nbits #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SOMA_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carry(carry)
`ifdef SOMA_SUB_EN
    , .ovf(ovf)
`endif
  );

  soma_serial_nbits #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SOMA_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
`ifdef SOMA_SUB_EN
    , .ovf(ovf4)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    int r;
    r = int'(x) + int'(y) + int'(c);
    return 9'(r);
  endfunction

  // Driver: issue one operation on the DIGIT=1 instance and wait for done.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int busy_n, output int lat, output logic got);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    exp_q.push_back(model_add(av, bv, cv));
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    got = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 0; a = 0; b = 0; cin = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
`ifdef SOMA_SUB_EN
    sub = 0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum); else passed++;
    checks++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry); else passed++;
    checks++; if ({busy4, done4, carry4, sum4} !== 11'h0)
      $display("FAIL reset_dut4: got %b%b%b %h expected all 0", busy4, done4, carry4, sum4); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] va[3] = '{8'h7F, 8'hFF, 8'h00};
    logic [7:0] vb[3] = '{8'h01, 8'h01, 8'h00};
    logic       vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] e;
    int bn, lat;
    logic got;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], bn, lat, got);
      e = exp_q.pop_front();
      checks++; if (!got) $display("FAIL dir_timeout[%0d]: got no done expected done", i); else passed++;
      checks++; if ({carry, sum} !== e)
        $display("FAIL dir_result[%0d]: got %b_%h expected %b_%h", i, carry, sum, e[8], e[7:0]); else passed++;
      checks++; if (busy_and_done_clean(bn, lat) == 0)
        $display("FAIL dir_timing[%0d]: got busy=%0d lat=%0d expected busy=8 lat=9", i, bn, lat); else passed++;
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00)
        $display("FAIL dir_pulse[%0d]: got done=%b busy=%b expected 0 0", i, done, busy); else passed++;
      checks++; if ({carry, sum} !== e)
        $display("FAIL dir_hold[%0d]: got %b_%h expected %b_%h", i, carry, sum, e[8], e[7:0]); else passed++;
    end
  endtask

  function automatic int busy_and_done_clean(input int bn, input int lat);
    return (bn == 8 && lat == 9) ? 1 : 0;
  endfunction

  task automatic test_start_ignored;
    int pulses = 0;
    logic [8:0] first = '0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    a = 8'hFF; start = 1;
    @(negedge clk);
    a = 8'h00; start = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        if (pulses == 0) first = {carry, sum};
        pulses++;
      end
      @(negedge clk);
    end
    checks++; if (pulses != 1) $display("FAIL ign_pulses: got %0d expected 1", pulses); else passed++;
    checks++; if (first !== 9'h046) $display("FAIL ign_result: got %h expected 046", first); else passed++;
  endtask

  task automatic test_reset_mid_run;
    int pulses = 0, busy_seen = 0, bn, lat;
    logic got;
    logic [8:0] e;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({busy, done, carry, sum} !== 11'h0)
      $display("FAIL rst_async: got busy=%b done=%b carry=%b sum=%h expected all 0", busy, done, carry, sum); else passed++;
    #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    checks++; if (pulses != 0) $display("FAIL rst_no_done: got %0d pulses expected 0", pulses); else passed++;
    checks++; if (busy_seen != 0) $display("FAIL rst_idle: got %0d busy cycles expected 0", busy_seen); else passed++;
    run_op(8'hAA, 8'h55, 1'b0, bn, lat, got);
    e = exp_q.pop_front();
    checks++; if (!got || {carry, sum} !== e)
      $display("FAIL rst_restart: got done=%b %b_%h expected 1 %b_%h", got, carry, sum, e[8], e[7:0]); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    a4 = 8'h9C; b4 = 8'h78; cin4 = 0; start4 = 1;
    @(negedge clk);
    lat = 1;
    while (!done4 && lat < 10) begin @(negedge clk); lat++; end
    checks++; if (lat != 3) $display("FAIL b2b_lat1: got %0d expected 3", lat); else passed++;
    checks++; if ({carry4, sum4} !== 9'h114) $display("FAIL b2b_res1: got %b_%h expected 1_14", carry4, sum4); else passed++;
    a4 = 8'h01; b4 = 8'h02; cin4 = 1;
    @(negedge clk);
    checks++; if (busy4 !== 1'b1) $display("FAIL b2b_no_idle: got busy=%b expected 1", busy4); else passed++;
    lat = 1;
    while (!done4 && lat < 10) begin @(negedge clk); lat++; end
    start4 = 0;
    checks++; if (lat != 3) $display("FAIL b2b_lat2: got %0d expected 3", lat); else passed++;
    checks++; if ({carry4, sum4} !== 9'h004) $display("FAIL b2b_res2: got %b_%h expected 0_04", carry4, sum4); else passed++;
    @(negedge clk);
    checks++; if ({done4, busy4} !== 2'b00) $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done4, busy4); else passed++;
  endtask

  // Random operands issued back to back on the DIGIT=1 instance.
  task automatic test_random;
    int n = 30, cyc;
    logic [8:0] e;
    @(negedge clk);
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
    start = 1;
    exp_q.push_back(model_add(a, b, cin));
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!done && cyc < 20) begin @(negedge clk); cyc++; end
      e = exp_q.pop_front();
      checks++; if (!done || cyc != 8 || busy)
        $display("FAIL rnd_timing[%0d]: got done=%b cyc=%0d busy=%b expected 1 8 0", i, done, cyc, busy); else passed++;
      checks++; if ({carry, sum} !== e)
        $display("FAIL rnd_result[%0d]: got %b_%h expected %b_%h", i, carry, sum, e[8], e[7:0]); else passed++;
      if (i < n - 1) begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
        exp_q.push_back(model_add(a, b, cin));
      end else begin
        start = 0;
      end
      @(negedge clk);
    end
  endtask

`ifdef SOMA_SUB_EN
  task automatic test_sub;
    logic [7:0] va[2] = '{8'h05, 8'h80};
    logic [7:0] vb[2] = '{8'h07, 8'h01};
    logic [9:0] e[2]  = '{10'b0_0_1111_1110, 10'b1_1_0111_1111};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; cin = 0; sub = 1; start = 1;
      @(negedge clk);
      start = 0; sub = 0;
      lat = 1;
      while (!done && lat < 20) begin @(negedge clk); lat++; end
      checks++; if ({ovf, carry, sum} !== e[i])
        $display("FAIL sub[%0d]: got ovf=%b carry=%b sum=%h expected %b %b %h", i, ovf, carry, sum, e[i][9], e[i][8], e[i][7:0]); else passed++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
`ifdef SOMA_SUB_EN
    test_sub;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
